// File: rtl/pwm_from_count.sv
// pwm_from_count: PWM generator driven by an external modulo-MOD count, with buffered duty updates
module pwm_from_count #(
   parameter int N   = 6,
   parameter int MOD = 50
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] count,
   input  logic [N:0]   duty,
   input  logic         duty_valid,
   output logic         duty_ready,
   output logic [N:0]   duty_active,
   output logic         pwm,
   output logic         period_done,
   output logic [7:0]   period_cnt,
   output logic         seq_err
);
   localparam logic [N:0] MODV = (N+1)'(MOD);
   localparam logic [N:0] LAST = (N+1)'(MOD - 1);

   logic         full;
   logic         armed;
   logic [N:0]   pending;
   logic [N-1:0] prev_count;
   logic [N:0]   cnt_x;
   logic [N:0]   prev_x;
   logic [N:0]   expect_x;
   logic [N:0]   clamped;
   logic         boundary;
   logic         accept;
   logic         bad;

   // handshake, clamping, boundary and sequence-continuity decode
   always_comb begin
      cnt_x      = {1'b0, count};
      prev_x     = {1'b0, prev_count};
      expect_x   = (prev_x == LAST) ? '0 : prev_x + 1'b1;
      boundary   = cnt_x == LAST;
      clamped    = (duty > MODV) ? MODV : duty;
      duty_ready = rst & ~full;
      accept     = duty_valid & duty_ready;
      bad        = (cnt_x >= MODV) | (cnt_x != expect_x);
   end

   // pending buffer and duty application at the period boundary
   always_ff @(posedge clk) begin
      if (!rst) begin
         full        <= 1'b0;
         pending     <= '0;
         duty_active <= '0;
      end else begin
         full <= accept | (full & ~boundary);
         if (accept) pending <= clamped;
         if (boundary & full) duty_active <= pending;
      end
   end

   // registered PWM output and period bookkeeping
   always_ff @(posedge clk) begin
      if (!rst) begin
         pwm         <= 1'b0;
         period_done <= 1'b0;
         period_cnt  <= '0;
      end else begin
         pwm         <= cnt_x < duty_active;
         period_done <= boundary;
         if (boundary) period_cnt <= period_cnt + 8'd1;
      end
   end

   // sticky check that count advances by one modulo MOD, skipping the first sample after reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         armed      <= 1'b0;
         prev_count <= '0;
         seq_err    <= 1'b0;
      end else begin
         armed      <= 1'b1;
         prev_count <= count;
         if (armed & bad) seq_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pwm_from_count.sv
// tb_pwm_from_count: directed self-checking bench for pwm_from_count with MOD = 50
module tb_pwm_from_count;
   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] count;
   logic [6:0] duty;
   logic       duty_valid;
   logic       duty_ready;
   logic [6:0] duty_active;
   logic       pwm;
   logic       period_done;
   logic [7:0] period_cnt;
   logic       seq_err;
   int         vectors = 0;
   int         miscompares = 0;

   pwm_from_count #(.N(6), .MOD(50)) dut (
      .clk(clk), .rst(rst), .count(count), .duty(duty), .duty_valid(duty_valid),
      .duty_ready(duty_ready), .duty_active(duty_active), .pwm(pwm),
      .period_done(period_done), .period_cnt(period_cnt), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   // one clock: outputs are sampled 1 time unit after the edge, then count advances
   task automatic tick();
      @(posedge clk);
      #1;
      count = (count == 6'd49) ? 6'd0 : count + 6'd1;
   endtask

   task automatic run_to(input logic [5:0] c);
      for (int i = 0; i < 100 && count != c; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      count = 6'd17;
      duty = 7'd5;
      duty_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({pwm, period_done, period_cnt, duty_active, duty_ready, seq_err} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state: got pwm=%b done=%b pcnt=%0d active=%0d ready=%b err=%b required all zero",
                     pwm, period_done, period_cnt, duty_active, duty_ready, seq_err);
         end
      end
      duty_valid = 1'b0;
      count = 6'd0;
      rst = 1'b1;
      #1;
      vectors++;
      if (duty_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_release: got %b required 1", duty_ready);
      end
   endtask

   task automatic test_normal_update();
      int highs;
      int dones;
      logic [5:0] was;
      run_to(6'd20);
      duty = 7'd10;
      duty_valid = 1'b1;
      tick();
      duty_valid = 1'b0;
      vectors++;
      if (duty_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ready_low_after_accept: got %b required 0", duty_ready);
      end
      run_to(6'd49);
      vectors++;
      if (duty_active !== 7'd0) begin
         miscompares++;
         $display("FAIL active_before_boundary: got %0d required 0", duty_active);
      end
      tick();
      vectors++;
      if (duty_active !== 7'd10 || duty_ready !== 1'b1 || period_done !== 1'b1) begin
         miscompares++;
         $display("FAIL apply_at_boundary: got active=%0d ready=%b done=%b required 10 1 1",
                  duty_active, duty_ready, period_done);
      end
      highs = 0;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         was = count;
         tick();
         highs += int'(pwm);
         dones += int'(period_done);
         vectors++;
         if (pwm !== (was < 6'd10)) begin
            miscompares++;
            $display("FAIL pwm_duty10: sampled count %0d got %b required %b", was, pwm, was < 6'd10);
         end
      end
      vectors++;
      if (highs != 10 || dones != 1) begin
         miscompares++;
         $display("FAIL period_duty10: got highs=%0d dones=%0d required 10 1", highs, dones);
      end
   endtask

   task automatic test_extremes();
      duty = 7'd0;
      duty_valid = 1'b1;
      tick();
      duty_valid = 1'b0;
      run_to(6'd49);
      tick();
      tick();
      for (int i = 0; i < 52; i++) begin
         tick();
         vectors++;
         if (pwm !== 1'b0) begin
            miscompares++;
            $display("FAIL pwm_duty0: count %0d got %b required 0", count, pwm);
         end
      end
      duty = 7'd63;
      duty_valid = 1'b1;
      tick();
      duty_valid = 1'b0;
      run_to(6'd49);
      tick();
      vectors++;
      if (duty_active !== 7'd50) begin
         miscompares++;
         $display("FAIL clamp_63: got %0d required 50", duty_active);
      end
      for (int i = 0; i < 52; i++) begin
         tick();
         vectors++;
         if (pwm !== 1'b1) begin
            miscompares++;
            $display("FAIL pwm_full: count %0d got %b required 1", count, pwm);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_to(6'd5);
      duty = 7'd20;
      duty_valid = 1'b1;
      tick();
      duty = 7'd30;
      while (count != 6'd49) begin
         vectors++;
         if (duty_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_wait_ready: count %0d got %b required 0", count, duty_ready);
         end
         tick();
      end
      tick();
      vectors++;
      if (duty_active !== 7'd20 || duty_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first_apply: got active=%0d ready=%b required 20 1", duty_active, duty_ready);
      end
      tick();
      duty_valid = 1'b0;
      vectors++;
      if (duty_active !== 7'd20 || duty_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_second_accept: got active=%0d ready=%b required 20 0", duty_active, duty_ready);
      end
      run_to(6'd49);
      tick();
      vectors++;
      if (duty_active !== 7'd30) begin
         miscompares++;
         $display("FAIL b2b_second_apply: got %0d required 30", duty_active);
      end
      run_to(6'd49);
      duty = 7'd15;
      duty_valid = 1'b1;
      tick();
      duty_valid = 1'b0;
      vectors++;
      if (duty_active !== 7'd30 || duty_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL accept_at_boundary: got active=%0d ready=%b required 30 0", duty_active, duty_ready);
      end
      run_to(6'd49);
      tick();
      vectors++;
      if (duty_active !== 7'd15 || duty_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL boundary_accept_apply: got active=%0d ready=%b required 15 1", duty_active, duty_ready);
      end
   endtask

   task automatic test_seq_err();
      vectors++;
      if (seq_err !== 1'b0) begin
         miscompares++;
         $display("FAIL seq_clean: got %b required 0", seq_err);
      end
      run_to(6'd10);
      tick();
      count = 6'd12;
      tick();
      vectors++;
      if (seq_err !== 1'b1) begin
         miscompares++;
         $display("FAIL seq_skip: got %b required 1", seq_err);
      end
      repeat (60) tick();
      vectors++;
      if (seq_err !== 1'b1) begin
         miscompares++;
         $display("FAIL seq_sticky: got %b required 1", seq_err);
      end
      run_to(6'd30);
      rst = 1'b0;
      tick();
      count = 6'd0;
      rst = 1'b1;
      #1;
      vectors++;
      if (seq_err !== 1'b0 || duty_active !== 7'd0 || duty_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset: got err=%b active=%0d ready=%b required 0 0 1", seq_err, duty_active, duty_ready);
      end
      repeat (60) tick();
      vectors++;
      if (seq_err !== 1'b0) begin
         miscompares++;
         $display("FAIL seq_after_reset: got %b required 0", seq_err);
      end
   endtask

   task automatic test_period_counter();
      logic [7:0] exp_pc;
      logic [5:0] was;
      int dones;
      bit wrapped;
      rst = 1'b0;
      tick();
      count = 6'd0;
      rst = 1'b1;
      exp_pc = 8'd0;
      dones = 0;
      wrapped = 1'b0;
      for (int i = 0; i < 256 * 50; i++) begin
         was = count;
         tick();
         if (was == 6'd49) begin
            exp_pc = exp_pc + 8'd1;
            dones++;
            if (exp_pc == 8'd0 && period_cnt === 8'd0) wrapped = 1'b1;
         end
         vectors++;
         if (period_done !== (was == 6'd49) || period_cnt !== exp_pc) begin
            miscompares++;
            $display("FAIL period_track: sampled %0d got done=%b pcnt=%0d required %b %0d",
                     was, period_done, period_cnt, was == 6'd49, exp_pc);
         end
      end
      vectors++;
      if (period_cnt !== 8'd0 || dones != 256 || !wrapped) begin
         miscompares++;
         $display("FAIL period_wrap: got pcnt=%0d periods=%0d wrapped=%b required 0 256 1",
                  period_cnt, dones, wrapped);
      end
   endtask

   initial begin
      test_reset();
      test_normal_update();
      test_extremes();
      test_back_to_back();
      test_seq_err();
      test_period_counter();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
